data_mem_ctrl: RTL and testbench

Data-side memory responder for the single-cycle RV32I core. It accepts the core's data-memory request signals (address, store data, read/write strobes, funct3 size selects) and returns load data in the same cycle. Internally it provides a byte-addressable word RAM, load sign/zero extension, misalignment detection with fault capture, and a small MMIO page containing a cycle counter, a GPIO register and fault status. It sits beside the core at top level, and its load-data output feeds the core's memory-data input directly.

---
 rtl/data_mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-side memory responder: byte-addressable word RAM, load formatting,
// misalignment capture and a small MMIO page (cycle counter, GPIO, fault status).
module data_mem_ctrl #(
   parameter int unsigned ADDR_W    = 10,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
   input  logic        clk_w_i,
   input  logic        res_w_i_h,
   input  logic [31:0] mem_addr_in_w_i,
   input  logic [31:0] mem_data_in_w_i,
   input  logic        mem_wr_w_i_h,
   input  logic        mem_rd_w_i_h,
   input  logic [2:0]  mem_wr_byte_sel_w_i,
   input  logic [2:0]  mem_rd_byte_sel_w_i,
   output logic [31:0] mem_data_w_o,
   output logic [31:0] gpio_w_o,
   output logic        misalign_w_o_h,
   output logic [31:0] fault_addr_w_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [5:0] REG_CYCLE_LO = 6'd0;
   localparam logic [5:0] REG_CYCLE_HI = 6'd1;
   localparam logic [5:0] REG_GPIO     = 6'd2;
   localparam logic [5:0] REG_STATUS   = 6'd3;
   localparam logic [5:0] REG_FAULT    = 6'd4;

   logic [31:0] mem_q [DEPTH];

   logic [63:0] cycle_q, cycle_d;
   logic [31:0] gpio_q, gpio_d;
   logic        misalign_q, misalign_d;
   logic [31:0] fault_addr_q, fault_addr_d;
   logic [15:0] fault_cnt_q, fault_cnt_d;

   logic [63:0] cycle_inc;
   assign cycle_inc = cycle_q + 64'd1;

   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        lane;
   logic [5:0]        mmio_word;
   logic              is_mmio;

   assign word_idx  = mem_addr_in_w_i[ADDR_W+1:2];
   assign lane      = mem_addr_in_w_i[1:0];
   assign mmio_word = mem_addr_in_w_i[7:2];
   assign is_mmio   = (mem_addr_in_w_i[31:8] == MMIO_BASE[31:8]);

   // Misalignment detection for both strobes
   logic ld_mis, st_mis, fault_c;
   always_comb begin
      ld_mis = 1'b0;
      st_mis = 1'b0;
      if ((mem_rd_byte_sel_w_i == F3_H || mem_rd_byte_sel_w_i == F3_HU) && lane[0])
         ld_mis = 1'b1;
      if (mem_rd_byte_sel_w_i == F3_W && lane != 2'b00)
         ld_mis = 1'b1;
      if (mem_wr_byte_sel_w_i == F3_H && lane[0])
         st_mis = 1'b1;
      if (mem_wr_byte_sel_w_i == F3_W && lane != 2'b00)
         st_mis = 1'b1;
      fault_c = (mem_rd_w_i_h && ld_mis) || (mem_wr_w_i_h && st_mis);
   end

   // MMIO read mux and raw word selection
   logic [31:0] mmio_rdata, raw_word;
   always_comb begin
      mmio_rdata = 32'd0;
      case (mmio_word)
         REG_CYCLE_LO: mmio_rdata = cycle_q[31:0];
         REG_CYCLE_HI: mmio_rdata = cycle_q[63:32];
         REG_GPIO:     mmio_rdata = gpio_q;
         REG_STATUS:   mmio_rdata = {fault_cnt_q, 15'd0, misalign_q};
         REG_FAULT:    mmio_rdata = fault_addr_q;
         default:      mmio_rdata = 32'd0;
      endcase
      raw_word = is_mmio ? mmio_rdata : mem_q[word_idx];
   end

   // Load formatter: lane select plus sign/zero extension
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   always_comb begin
      sel_byte     = 8'(raw_word >> {lane, 3'b000});
      sel_half     = lane[1] ? raw_word[31:16] : raw_word[15:0];
      mem_data_w_o = 32'd0;
      if (mem_rd_w_i_h && !ld_mis) begin
         case (mem_rd_byte_sel_w_i)
            F3_B:    mem_data_w_o = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    mem_data_w_o = {{16{sel_half[15]}}, sel_half};
            F3_W:    mem_data_w_o = raw_word;
            F3_BU:   mem_data_w_o = {24'd0, sel_byte};
            F3_HU:   mem_data_w_o = {16'd0, sel_half};
            default: mem_data_w_o = 32'd0;
         endcase
      end
   end

   // Store byte enables and lane-replicated write data
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic        ram_we, mmio_sw;
   always_comb begin
      st_be    = 4'b0000;
      st_wdata = 32'd0;
      case (mem_wr_byte_sel_w_i)
         F3_B: begin
            st_be    = 4'b0001 << lane;
            st_wdata = {4{mem_data_in_w_i[7:0]}};
         end
         F3_H: begin
            st_be    = lane[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{mem_data_in_w_i[15:0]}};
         end
         F3_W: begin
            st_be    = 4'b1111;
            st_wdata = mem_data_in_w_i;
         end
         default: begin
            st_be    = 4'b0000;
            st_wdata = 32'd0;
         end
      endcase
      ram_we  = mem_wr_w_i_h && !res_w_i_h && !is_mmio && !st_mis;
      mmio_sw = mem_wr_w_i_h && !res_w_i_h && is_mmio &&
                (mem_wr_byte_sel_w_i == F3_W) && (lane == 2'b00);
   end

   always_ff @(posedge clk_w_i) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we && st_be[i])
            mem_q[word_idx][8*i +: 8] <= st_wdata[8*i +: 8];
      end
   end

   // Register next-state; a new fault overrides a same-cycle STATUS clear
   always_comb begin
      cycle_d      = cycle_inc;
      gpio_d       = gpio_q;
      misalign_d   = misalign_q;
      fault_addr_d = fault_addr_q;
      fault_cnt_d  = fault_cnt_q;
      if (mmio_sw && mmio_word == REG_GPIO)
         gpio_d = mem_data_in_w_i;
      if (mmio_sw && mmio_word == REG_STATUS && mem_data_in_w_i[0])
         misalign_d = 1'b0;
      if (fault_c) begin
         misalign_d   = 1'b1;
         fault_addr_d = mem_addr_in_w_i;
         if (fault_cnt_q != 16'hFFFF)
            fault_cnt_d = fault_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_w_i) begin
      if (res_w_i_h) begin
         cycle_q      <= 64'd0;
         gpio_q       <= 32'd0;
         misalign_q   <= 1'b0;
         fault_addr_q <= 32'd0;
         fault_cnt_q  <= 16'd0;
      end else begin
         cycle_q      <= cycle_d;
         gpio_q       <= gpio_d;
         misalign_q   <= misalign_d;
         fault_addr_q <= fault_addr_d;
         fault_cnt_q  <= fault_cnt_d;
      end
   end

   assign gpio_w_o       = gpio_q;
   assign misalign_w_o_h = misalign_q;
   assign fault_addr_w_o = fault_addr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: RAM formatting, misalignment, MMIO and counter.
module tb_data_mem_ctrl;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
   localparam logic [31:0] A_CLO = 32'hFFFF_FF00, A_CHI = 32'hFFFF_FF04, A_GPIO = 32'hFFFF_FF08;
   localparam logic [31:0] A_STAT = 32'hFFFF_FF0C, A_FADDR = 32'hFFFF_FF10;

   logic        clk, rst;
   logic [31:0] addr, wdata;
   logic        wr, rd;
   logic [2:0]  wsel, rsel;
   logic [31:0] rdata, gpio, faddr;
   logic        mis;

   int total = 0;
   int bad   = 0;

   data_mem_ctrl dut (
      .clk_w_i             (clk),
      .res_w_i_h           (rst),
      .mem_addr_in_w_i     (addr),
      .mem_data_in_w_i     (wdata),
      .mem_wr_w_i_h        (wr),
      .mem_rd_w_i_h        (rd),
      .mem_wr_byte_sel_w_i (wsel),
      .mem_rd_byte_sel_w_i (rsel),
      .mem_data_w_o        (rdata),
      .gpio_w_o            (gpio),
      .misalign_w_o_h      (mis),
      .fault_addr_w_o      (faddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      @(negedge clk);
      addr = a; wdata = d; wsel = f3; wr = 1'b1;
      @(posedge clk);
      #1 wr = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] d);
      @(negedge clk);
      addr = a; rsel = f3; rd = 1'b1;
      #1 d = rdata;
      @(posedge clk);
      #1 rd = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (gpio !== 32'd0) begin bad++; $display("FAIL reset_gpio got=%h exp=%h", gpio, 32'd0); end
      total++; if (mis !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", mis); end
      total++; if (faddr !== 32'd0) begin bad++; $display("FAIL reset_fault_addr got=%h exp=%h", faddr, 32'd0); end
      @(negedge clk);
      rst = 1'b0; addr = A_GPIO; rsel = LW; rd = 1'b0;
      #1;
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL idle_output got=%h exp=%h", rdata, 32'd0); end
      do_load(A_STAT, LW, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, 32'd0); end
   endtask

   task automatic test_roundtrip;
      logic [31:0] d;
      do_store(32'h10, 32'h8000_80F0, LW);
      do_load(32'h10, LB, d);
      total++; if (d !== 32'hFFFF_FFF0) begin bad++; $display("FAIL rt_lb got=%h exp=%h", d, 32'hFFFF_FFF0); end
      do_load(32'h10, LBU, d);
      total++; if (d !== 32'h0000_00F0) begin bad++; $display("FAIL rt_lbu got=%h exp=%h", d, 32'h0000_00F0); end
      do_load(32'h12, LH, d);
      total++; if (d !== 32'hFFFF_8000) begin bad++; $display("FAIL rt_lh got=%h exp=%h", d, 32'hFFFF_8000); end
      do_load(32'h12, LHU, d);
      total++; if (d !== 32'h0000_8000) begin bad++; $display("FAIL rt_lhu got=%h exp=%h", d, 32'h0000_8000); end
      do_load(32'h10, LW, d);
      total++; if (d !== 32'h8000_80F0) begin bad++; $display("FAIL rt_lw got=%h exp=%h", d, 32'h8000_80F0); end
      do_load(32'h11, LBU, d);
      total++; if (d !== 32'h0000_0080) begin bad++; $display("FAIL rt_lbu1 got=%h exp=%h", d, 32'h0000_0080); end
   endtask

   task automatic test_merge;
      logic [31:0] d;
      do_store(32'h20, 32'h0, LW);
      do_store(32'h23, 32'h0000_00AB, LB);
      do_store(32'h20, 32'h0000_1234, LH);
      do_load(32'h20, LW, d);
      total++; if (d !== 32'hAB00_1234) begin bad++; $display("FAIL merge_lw got=%h exp=%h", d, 32'hAB00_1234); end
      do_store(32'h22, 32'hFFFF_5678, LH);
      do_load(32'h20, LW, d);
      total++; if (d !== 32'h5678_1234) begin bad++; $display("FAIL merge_sh_hi got=%h exp=%h", d, 32'h5678_1234); end
   endtask

   task automatic test_misalign;
      logic [31:0] d;
      do_store(32'h30, 32'h1122_3344, LW);
      do_store(32'h31, 32'hDEAD_BEEF, LW);
      do_load(32'h30, LW, d);
      total++; if (d !== 32'h1122_3344) begin bad++; $display("FAIL mis_store_suppressed got=%h exp=%h", d, 32'h1122_3344); end
      total++; if (mis !== 1'b1) begin bad++; $display("FAIL mis_flag_set got=%b exp=1", mis); end
      total++; if (faddr !== 32'h31) begin bad++; $display("FAIL mis_fault_addr got=%h exp=%h", faddr, 32'h31); end
      do_load(A_STAT, LW, d);
      total++; if (d !== 32'h0001_0001) begin bad++; $display("FAIL mis_status got=%h exp=%h", d, 32'h0001_0001); end
      do_store(A_STAT, 32'h1, LW);
      total++; if (mis !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", mis); end
      do_load(A_STAT, LW, d);
      total++; if (d !== 32'h0001_0000) begin bad++; $display("FAIL mis_status_cleared got=%h exp=%h", d, 32'h0001_0000); end
      do_load(32'h33, LH, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL mis_load_zero got=%h exp=%h", d, 32'd0); end
      total++; if (faddr !== 32'h33) begin bad++; $display("FAIL mis_load_addr got=%h exp=%h", faddr, 32'h33); end
      do_load(A_STAT, LW, d);
      total++; if (d !== 32'h0002_0001) begin bad++; $display("FAIL mis_status_two got=%h exp=%h", d, 32'h0002_0001); end
      do_load(A_FADDR, LW, d);
      total++; if (d !== 32'h33) begin bad++; $display("FAIL mis_faddr_reg got=%h exp=%h", d, 32'h33); end
   endtask

   task automatic test_unsupported;
      logic [31:0] d;
      do_load(32'h30, 3'b011, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL unsup_load got=%h exp=%h", d, 32'd0); end
      do_store(32'h30, 32'hFFFF_FFFF, 3'b111);
      do_load(32'h30, LW, d);
      total++; if (d !== 32'h1122_3344) begin bad++; $display("FAIL unsup_store got=%h exp=%h", d, 32'h1122_3344); end
      do_load(A_STAT, LW, d);
      total++; if (d !== 32'h0002_0001) begin bad++; $display("FAIL unsup_nofault got=%h exp=%h", d, 32'h0002_0001); end
   endtask

   task automatic test_gpio;
      logic [31:0] d;
      do_store(A_GPIO, 32'h5A5A_0001, LW);
      total++; if (gpio !== 32'h5A5A_0001) begin bad++; $display("FAIL gpio_sw got=%h exp=%h", gpio, 32'h5A5A_0001); end
      do_store(A_GPIO, 32'h0000_0077, LB);
      total++; if (gpio !== 32'h5A5A_0001) begin bad++; $display("FAIL gpio_sb_ignored got=%h exp=%h", gpio, 32'h5A5A_0001); end
      do_load(A_GPIO + 32'd3, LB, d);
      total++; if (d !== 32'h0000_005A) begin bad++; $display("FAIL gpio_lb3 got=%h exp=%h", d, 32'h0000_005A); end
      do_load(32'hFFFF_FF14, LW, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL mmio_unmapped got=%h exp=%h", d, 32'd0); end
      do_store(A_GPIO, 32'h0000_8100, LW);
      do_load(A_GPIO + 32'd1, LB, d);
      total++; if (d !== 32'hFFFF_FF81) begin bad++; $display("FAIL gpio_lb1_sext got=%h exp=%h", d, 32'hFFFF_FF81); end
   endtask

   task automatic test_same_cycle;
      logic [31:0] d;
      do_store(32'h40, 32'h1111_1111, LW);
      @(negedge clk);
      addr = 32'h40; wdata = 32'h2222_2222; wsel = LW; rsel = LW; wr = 1'b1; rd = 1'b1;
      #1;
      total++; if (rdata !== 32'h1111_1111) begin bad++; $display("FAIL rw_pre_write got=%h exp=%h", rdata, 32'h1111_1111); end
      @(posedge clk);
      #1 wr = 1'b0; rd = 1'b0;
      do_load(32'h40, LW, d);
      total++; if (d !== 32'h2222_2222) begin bad++; $display("FAIL rw_post_write got=%h exp=%h", d, 32'h2222_2222); end
   endtask

   task automatic test_counter;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; addr = A_CLO; rsel = LW; rd = 1'b1;
      #1;
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL cnt_k0 got=%h exp=%h", rdata, 32'd0); end
      @(negedge clk);
      #1;
      total++; if (rdata !== 32'd1) begin bad++; $display("FAIL cnt_k1 got=%h exp=%h", rdata, 32'd1); end
      repeat (4) @(negedge clk);
      #1;
      total++; if (rdata !== 32'd5) begin bad++; $display("FAIL cnt_k5 got=%h exp=%h", rdata, 32'd5); end
      @(negedge clk);
      force dut.cycle_inc = 64'h0000_0000_FFFF_FFFF;
      @(negedge clk);
      release dut.cycle_inc;
      #1;
      total++; if (rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cnt_preload got=%h exp=%h", rdata, 32'hFFFF_FFFF); end
      addr = A_CHI;
      #1;
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL cnt_hi_before got=%h exp=%h", rdata, 32'd0); end
      @(negedge clk);
      #1;
      total++; if (rdata !== 32'd1) begin bad++; $display("FAIL cnt_hi_carry got=%h exp=%h", rdata, 32'd1); end
      addr = A_CLO;
      #1;
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL cnt_lo_wrap got=%h exp=%h", rdata, 32'd0); end
      rd = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      do_store(32'h50, 32'hAAAA_AAAA, LW);
      do_store(A_GPIO, 32'h0000_1234, LW);
      do_store(32'h31, 32'h0, LW);
      @(negedge clk);
      rst = 1'b1; addr = A_GPIO; wdata = 32'h1; wsel = LW; wr = 1'b1;
      @(posedge clk);
      #1;
      total++; if (gpio !== 32'd0) begin bad++; $display("FAIL rstmid_gpio got=%h exp=%h", gpio, 32'd0); end
      total++; if (mis !== 1'b0) begin bad++; $display("FAIL rstmid_mis got=%b exp=0", mis); end
      @(negedge clk);
      addr = 32'h50; wdata = 32'h5555_5555;
      @(negedge clk);
      addr = 32'h31;
      @(posedge clk);
      #1;
      total++; if (mis !== 1'b0) begin bad++; $display("FAIL rstmid_fault_dropped got=%b exp=0", mis); end
      total++; if (gpio !== 32'd0) begin bad++; $display("FAIL rstmid_gpio_hold got=%h exp=%h", gpio, 32'd0); end
      @(negedge clk);
      wr = 1'b0; rst = 1'b0; addr = A_CLO; rsel = LW; rd = 1'b1;
      #1;
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rstmid_counter got=%h exp=%h", rdata, 32'd0); end
      rd = 1'b0;
      do_load(32'h50, LW, d);
      total++; if (d !== 32'hAAAA_AAAA) begin bad++; $display("FAIL rstmid_ram_store got=%h exp=%h", d, 32'hAAAA_AAAA); end
      do_load(A_STAT, LW, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL rstmid_status got=%h exp=%h", d, 32'd0); end
   endtask

   initial begin
      rst = 1'b1; addr = 32'd0; wdata = 32'd0; wr = 1'b0; rd = 1'b0; wsel = LW; rsel = LW;
      test_reset();
      test_roundtrip();
      test_merge();
      test_misalign();
      test_unsupported();
      test_gpio();
      test_same_cycle();
      test_counter();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
